tt_vec_sequencer: RTL and testbench
===================================

# tt_vec_sequencer

Parametrised on-chip vector sequencer for Tiny Tapeout user designs. It stores up to DEPTH stimulus/expected/mask triples and plays the stimulus onto a user-design input bus, one vector per enabled cycle. It compares the returning output bus after a fixed pipeline latency and reports the mismatch count and the first failing index. It sits between the `tt_um_*` pin wrapper and the design core, so silicon bring-up can exercise the core without an external pattern generator.

## Interface
Parameters:
- WIDTH, 8, stimulus/response bus width (1..16)
- DEPTH, 16, vector memory entries (power of two, 2..64)
- LAT, 2, cycles from stim_out change to corresponding resp_in sample (1..8)
- IDLE_VALUE, 0, stim_out value when not running

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- ena  in  1  cycle enable; low = full stall, all state held
- wr_en  in  1  write vector memory entry (ignored while busy)
- wr_addr  in  clog2(DEPTH)  entry index
- wr_stim / wr_exp / wr_mask  in  WIDTH  stimulus, expected response, compare mask (1 = compare bit)
- num_vec  in  clog2(DEPTH)+1  vectors to run, sampled at start; 0 treated as 1, >DEPTH clamped to DEPTH
- start  in  1  begin run (ignored while busy)
- stim_out  out  WIDTH  to core inputs
- resp_in  in  WIDTH  from core outputs
- busy  out  1  run in progress
- done  out  1  run complete; held until next accepted start
- pass  out  1  done and err_count == 0
- err_count  out  clog2(DEPTH)+1  masked mismatches in last run
- first_err_idx  out  clog2(DEPTH)  index of first mismatch; valid when first_err_vld
- first_err_vld  out  1  at least one mismatch seen
- rd_addr  in  clog2(DEPTH)  capture read index
- rd_data  out  WIDTH  captured response (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE. All transitions require ena=1.
- IDLE/DONE + start=1: latch N, clear err_count, first_err_vld, and done; go to RUN. stim_out <= stim[0]; issue index 0 into the LAT-deep tag pipe.
- RUN: each enabled edge issues the next index (stim_out <= stim[i]). After issuing N-1, go to DRAIN. stim_out <= IDLE_VALUE.
- DRAIN: no new issue. When the tag pipe empties (last compare done), go to DONE.
- Compare on each enabled edge where the pipe head is valid with index i: mismatch = |((resp_in ^ exp[i]) & mask[i]).
  - Mismatch increments err_count (max DEPTH, no overflow possible).
  - First mismatch loads first_err_idx=i and sets first_err_vld.
- The write port is accepted only in IDLE/DONE. A write during RUN/DRAIN is dropped, with no side effect.
- Vector memory is not cleared by reset. Contents are undefined until written and are preserved across reset.

## Timing
- Reset values: stim_out=IDLE_VALUE, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_vld=0, rd_data=0, state IDLE, tag pipe empty.
- Start accepted at edge E0. Vector i appears on stim_out after edge E0+i. resp_in for vector i is sampled at edge E0+i+LAT (counting enabled edges only).
- busy=1 from after E0 through the final compare edge E0+N-1+LAT. done=1 and busy=0 immediately after that edge.
- pass is combinational from done and err_count.
- ena=0 holds stim_out, the tag pipe, and counters. Stalls stretch timing one-for-one.
- start on the same edge that DONE is entered: ignored (busy still 1 that cycle).
- rst_n=0 mid-run: abort to IDLE with reset values on the next edge. No partial done.

## Configuration
- TT_VEC_CAPTURE_EN defined:
  - An additional DEPTH×WIDTH capture RAM stores resp_in at each compare for index i.
  - rd_data = cap[rd_addr], registered (1-cycle read latency).
  - Captures from an aborted run are retained but are unspecified.
- Undefined: no capture RAM is built and rd_data is tied to 0. The rd_addr and rd_data ports remain present.

## Test plan
- WIDTH=8, LAT=2. Load 4 vectors with stim=exp=0x11,0x22,0x33,0x44 and mask=0xFF. DUT model is a 2-cycle delay. Start -> done after 5 cycles, pass=1, err_count=0.
- Same as above, but exp[2]=0x37 with mask[2]=0xFB -> pass=1. Then mask[2]=0xFF -> err_count=1, first_err_idx=2, first_err_vld=1.
- Corrupt vectors 1 and 3 -> err_count=2, first_err_idx=1.
- ena toggles 1,0 every cycle during the run -> identical results, and busy length doubles.
- rst_n low at cycle 2 of the run -> busy=0, done=0, stim_out=0x00 after the next edge. A new start runs cleanly.
- With TT_VEC_CAPTURE_EN, after the first test: rd_addr=3 -> rd_data=0x44 one cycle later. num_vec=0 runs one vector. A write during busy leaves the memory unchanged.

Source files
------------

// File: rtl/tt_vec_sequencer.sv
// tt_vec_sequencer: on-chip stimulus/expected/mask vector player for Tiny
// Tapeout bring-up. Drives stim_out one vector per enabled cycle, compares
// resp_in LAT enabled cycles later, and reports the mismatch count and the
// first failing index.
// Optional build macro: TT_VEC_CAPTURE_EN adds a response capture RAM that
// is read back through rd_addr/rd_data. When it is undefined, rd_data is 0.
module tt_vec_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LAT = 2,
    parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_stim,
    input  logic [WIDTH-1:0]           wr_exp,
    input  logic [WIDTH-1:0]           wr_mask,
    input  logic [$clog2(DEPTH):0]     num_vec,
    input  logic                       start,
    output logic [WIDTH-1:0]           stim_out,
    input  logic [WIDTH-1:0]           resp_in,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(DEPTH):0]     err_count,
    output logic [$clog2(DEPTH)-1:0]   first_err_idx,
    output logic                       first_err_vld,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    // Vector memories are deliberately not reset; contents survive rst_n.
    logic [WIDTH-1:0] stim_mem [DEPTH];
    logic [WIDTH-1:0] exp_mem  [DEPTH];
    logic [WIDTH-1:0] mask_mem [DEPTH];

    // Tag pipe: stage 0 receives the issued index, stage LAT-1 is the head.
    logic          pipe_vld [LAT];
    logic [AW-1:0] pipe_idx [LAT];

    logic          head_vld;
    logic [AW-1:0] head_idx;
    logic          mismatch;

    logic [AW-1:0] n_last_in, n_last_q;
    logic [AW-1:0] ptr_q;
    logic          accept, issue, to_idle_stim;
    logic [AW-1:0] issue_idx;
    logic          wr_ok;

    logic [WIDTH-1:0] stim_q;
    logic [CW-1:0]    err_q;
    logic [AW-1:0]    fe_idx_q;
    logic             fe_vld_q;

    assign head_vld = pipe_vld[LAT-1];
    assign head_idx = pipe_idx[LAT-1];
    assign mismatch = head_vld &&
                      (|((resp_in ^ exp_mem[head_idx]) & mask_mem[head_idx]));
    assign wr_ok    = ena && wr_en && (state_q == IDLE || state_q == DONE);

    // Convert the requested vector count to a last index (0 -> 1, >DEPTH -> DEPTH).
    always_comb begin
        n_last_in = '0;
        if (num_vec == '0)
            n_last_in = '0;
        else if (num_vec > CW'(DEPTH))
            n_last_in = AW'(DEPTH - 1);
        else
            n_last_in = AW'(num_vec - CW'(1));
    end

    // State register; ena low freezes the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else if (ena)
            state_q <= state_d;
    end

    // Next state and issue control.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        issue        = 1'b0;
        issue_idx    = '0;
        to_idle_stim = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    issue     = 1'b1;
                    issue_idx = '0;
                    state_d   = (n_last_in == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                issue     = 1'b1;
                issue_idx = ptr_q;
                if (ptr_q == n_last_q)
                    state_d = DRAIN;
            end
            DRAIN: begin
                to_idle_stim = 1'b1;
                // Head carrying the last index means this edge is the final compare.
                if (head_vld && head_idx == n_last_q)
                    state_d = DONE;
            end
        endcase
    end

    // Vector memory write port, locked out while a run is in progress.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            stim_mem[wr_addr] <= wr_stim;
            exp_mem[wr_addr]  <= wr_exp;
            mask_mem[wr_addr] <= wr_mask;
        end
    end

    // Tag pipe shift: one stage per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_idx[k] <= '0;
            end
        end else if (ena) begin
            pipe_vld[0] <= issue;
            pipe_idx[0] <= issue_idx;
            for (int unsigned k = 1; k < LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_idx[k] <= pipe_idx[k-1];
            end
        end
    end

    // Stimulus output, issue pointer and latched run length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stim_q   <= IDLE_VALUE;
            ptr_q    <= '0;
            n_last_q <= '0;
        end else if (ena) begin
            if (accept) begin
                n_last_q <= n_last_in;
                ptr_q    <= AW'(1);
            end else if (issue) begin
                ptr_q <= ptr_q + AW'(1);
            end
            if (issue)
                stim_q <= stim_mem[issue_idx];
            else if (to_idle_stim)
                stim_q <= IDLE_VALUE;
        end
    end

    // Compare bookkeeping: error count and first failing index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q    <= '0;
            fe_idx_q <= '0;
            fe_vld_q <= 1'b0;
        end else if (ena) begin
            if (accept) begin
                err_q    <= '0;
                fe_vld_q <= 1'b0;
            end else if (mismatch) begin
                err_q <= err_q + CW'(1);
                if (!fe_vld_q) begin
                    fe_vld_q <= 1'b1;
                    fe_idx_q <= head_idx;
                end
            end
        end
    end

`ifdef TT_VEC_CAPTURE_EN
    logic [WIDTH-1:0] cap_mem [DEPTH];

    // Capture the sampled response at each compare.
    always_ff @(posedge clk) begin
        if (ena && head_vld)
            cap_mem[head_idx] <= resp_in;
    end

    // Registered capture read port.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_data <= '0;
        else if (ena)
            rd_data <= cap_mem[rd_addr];
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

    assign stim_out      = stim_q;
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign pass          = done && (err_q == '0);
    assign err_count     = err_q;
    assign first_err_idx = fe_idx_q;
    assign first_err_vld = fe_vld_q;

endmodule

// File: tb/tb_tt_vec_sequencer.sv
// Directed bench for tt_vec_sequencer (WIDTH=8, DEPTH=16, LAT=2).
// The core stand-in is one register stage advancing on enabled cycles, so a
// vector driven after edge E0+i is seen on resp_in at compare edge E0+i+2.
module tb_tt_vec_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, ena, wr_en, start;
    logic [3:0] wr_addr, rd_addr, first_err_idx;
    logic [7:0] wr_stim, wr_exp, wr_mask, stim_out, resp_in, rd_data;
    logic [4:0] num_vec, err_count;
    logic       busy, done, pass, first_err_vld;
    logic [7:0] core_q;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [7:0] s0;

    always #5 clk = ~clk;

    tt_vec_sequencer #(
        .WIDTH(8),
        .DEPTH(16),
        .LAT(2),
        .IDLE_VALUE(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
        .wr_exp(wr_exp), .wr_mask(wr_mask), .num_vec(num_vec),
        .start(start), .stim_out(stim_out), .resp_in(resp_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_vld(first_err_vld),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Core stand-in: one register stage, stalled with ena like the sequencer.
    always_ff @(posedge clk) begin
        if (ena)
            core_q <= stim_out;
    end
    assign resp_in = core_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] s, input logic [7:0] e,
                      input logic [7:0] m);
        wr_en = 1'b1; wr_addr = a; wr_stim = s; wr_exp = e; wr_mask = m;
        step;
        wr_en = 1'b0;
    endtask

    // Start a run and count cycles until busy drops (bounded).
    task automatic run(input logic [4:0] nv, input bit tog, output int n,
                       output logic [7:0] first);
        num_vec = nv; start = 1'b1;
        step;
        start = 1'b0;
        check("busy_at_start", busy, 1);
        first = stim_out;
        n = 0;
        while (busy && n < 400) begin
            if (tog) ena = (n % 2 == 1);
            step;
            n++;
        end
        ena = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; start = 1'b0;
        wr_addr = '0; wr_stim = '0; wr_exp = '0; wr_mask = '0;
        num_vec = '0; rd_addr = '0;
        step; step;
        check("rst_stim", stim_out, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_feidx", first_err_idx, 0);
        check("rst_fevld", first_err_vld, 0);
        check("rst_rddata", rd_data, 8'h00);
        rst_n = 1'b1;
        step;

        // Basic 4-vector run, stim == exp.
        wr(4'd0, 8'h11, 8'h11, 8'hFF);
        wr(4'd1, 8'h22, 8'h22, 8'hFF);
        wr(4'd2, 8'h33, 8'h33, 8'hFF);
        wr(4'd3, 8'h44, 8'h44, 8'hFF);
        run(5'd4, 1'b0, cyc, s0);
        check("t1_first_stim", s0, 8'h11);
        check("t1_busy_cycles", cyc, 5);
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);
        check("t1_fevld", first_err_vld, 0);
        check("t1_stim_idle", stim_out, 8'h00);

`ifdef TT_VEC_CAPTURE_EN
        rd_addr = 4'd3;
        step;
        check("cap_rd3", rd_data, 8'h44);
`else
        rd_addr = 4'd3;
        step;
        check("nocap_rd_zero", rd_data, 8'h00);
`endif

        // Masked-out difference on bit 2 passes.
        wr(4'd2, 8'h33, 8'h37, 8'hFB);
        run(5'd4, 1'b0, cyc, s0);
        check("t2_pass_masked", pass, 1);
        check("t2_err_masked", err_count, 0);
        // Same difference, now compared.
        wr(4'd2, 8'h33, 8'h37, 8'hFF);
        run(5'd4, 1'b0, cyc, s0);
        check("t2_err", err_count, 1);
        check("t2_feidx", first_err_idx, 2);
        check("t2_fevld", first_err_vld, 1);
        check("t2_pass", pass, 0);

        // Vectors 1 and 3 corrupted.
        wr(4'd2, 8'h33, 8'h33, 8'hFF);
        wr(4'd1, 8'h22, 8'h20, 8'hFF);
        wr(4'd3, 8'h44, 8'h40, 8'hFF);
        run(5'd4, 1'b0, cyc, s0);
        check("t3_err", err_count, 2);
        check("t3_feidx", first_err_idx, 1);
        check("t3_cycles", cyc, 5);

        // Alternating ena: same results, twice the busy length.
        run(5'd4, 1'b1, cyc, s0);
        check("t4_err", err_count, 2);
        check("t4_feidx", first_err_idx, 1);
        check("t4_cycles", cyc, 10);
        check("t4_done", done, 1);

        // Write attempted during busy must be dropped.
        wr(4'd1, 8'h22, 8'h22, 8'hFF);
        wr(4'd3, 8'h44, 8'h44, 8'hFF);
        num_vec = 5'd4; start = 1'b1;
        step;
        start = 1'b0;
        wr(4'd0, 8'h99, 8'h99, 8'h0F);
        cyc = 0;
        while (busy && cyc < 400) begin
            step;
            cyc++;
        end
        check("t5_busy_drained", busy, 0);
        run(5'd4, 1'b0, cyc, s0);
        check("t5_mem_kept_stim", s0, 8'h11);
        check("t5_mem_kept_pass", pass, 1);

        // num_vec = 0 runs one vector.
        run(5'd0, 1'b0, cyc, s0);
        check("t6_nv0_cycles", cyc, 2);
        check("t6_nv0_pass", pass, 1);

        // num_vec above DEPTH clamps to 16 vectors.
        for (int i = 4; i < 16; i++)
            wr(4'(i), 8'(i * 3 + 5), 8'(i * 3 + 5), 8'hFF);
        run(5'd20, 1'b0, cyc, s0);
        check("t7_clamp_cycles", cyc, 17);
        check("t7_clamp_pass", pass, 1);

        // Reset in the middle of a run.
        num_vec = 5'd4; start = 1'b1;
        step;
        start = 1'b0;
        step;
        rst_n = 1'b0;
        step;
        check("t8_rst_busy", busy, 0);
        check("t8_rst_done", done, 0);
        check("t8_rst_stim", stim_out, 8'h00);
        check("t8_rst_err", err_count, 0);
        rst_n = 1'b1;
        step;
        run(5'd4, 1'b0, cyc, s0);
        check("t8_rerun_cycles", cyc, 5);
        check("t8_rerun_pass", pass, 1);
        check("t8_rerun_stim", s0, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
